// File: rtl/mask_compact_packer_if.sv
// Frame-in / beat-out stream bundle for the mask compaction packer.
// The slave side is the packer; the master side is whoever feeds frames and drains beats.
interface mask_compact_packer_if #(
  parameter int N         = 128,
  parameter int DATA_W    = 8,
  parameter int PSUM_W    = 8,
  parameter int OUT_LANES = 16
);
  localparam int CNT_W = $clog2(OUT_LANES) + 1;

  logic                        in_valid;
  logic                        in_ready;
  logic [N-1:0]                in_mask;
  logic [N*DATA_W-1:0]         in_data;
  logic [N*PSUM_W-1:0]         in_psum;
  logic                        out_valid;
  logic                        out_ready;
  logic [OUT_LANES*DATA_W-1:0] out_data;
  logic [CNT_W-1:0]            out_count;
  logic                        out_last;

  modport slave (
    input  in_valid, in_mask, in_data, in_psum, out_ready,
    output in_ready, out_valid, out_data, out_count, out_last
  );

  modport master (
    output in_valid, in_mask, in_data, in_psum, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_last
  );
endinterface

// File: rtl/mask_compact_packer.sv
// Scatters the kept lanes of a frame into a dense buffer using the prefix sums,
// then streams that buffer out as OUT_LANES-wide beats with a count and last flag.
module mask_compact_packer #(
  parameter int N         = 128,
  parameter int DATA_W    = 8,
  parameter int PSUM_W    = 8,
  parameter int OUT_LANES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  mask_compact_packer_if.slave  bus
);
  localparam int PTR_W = $clog2(N + 1);
  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(OUT_LANES) + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  total_q, total_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] lane_buf_q [N];
  logic [DATA_W-1:0] lane_buf_d [N];

  logic [PTR_W-1:0]  remain;
  logic              beat_last;
  logic [CNT_W-1:0]  beat_cnt;
  logic              accept;
  logic              consume;
  logic [PTR_W-1:0]  rd_sum;
  logic [PSUM_W-1:0] psum_i;
  logic [IDX_W-1:0]  wr_idx;
  logic [OUT_LANES*DATA_W-1:0] out_data_c;

  // Beat geometry derives only from registered state, so outputs hold under backpressure.
  always_comb begin : beat_decode
    remain    = total_q - ptr_q;
    beat_last = (remain <= PTR_W'(OUT_LANES));
    beat_cnt  = beat_last ? CNT_W'(remain) : CNT_W'(OUT_LANES);
  end

  assign bus.in_ready = (state_q == IDLE) ||
                        ((state_q == DRAIN) && beat_last && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign consume      = (state_q == DRAIN) && bus.out_ready;

  always_comb begin : beat_mux
    out_data_c = '0;
    rd_sum     = '0;
    for (int l = 0; l < OUT_LANES; l++) begin
      rd_sum = ptr_q + PTR_W'(l);
      if ((state_q == DRAIN) && (CNT_W'(l) < beat_cnt) && (rd_sum < PTR_W'(N))) begin
        out_data_c[l*DATA_W +: DATA_W] = lane_buf_q[IDX_W'(rd_sum)];
      end
    end
  end

  assign bus.out_valid = (state_q == DRAIN);
  assign bus.out_data  = out_data_c;
  assign bus.out_count = (state_q == DRAIN) ? beat_cnt : '0;
  assign bus.out_last  = (state_q == DRAIN) && beat_last;

  // A new frame accepted on the last-beat edge overrides the return to IDLE.
  always_comb begin : next_state
    state_d    = state_q;
    total_d    = total_q;
    ptr_d      = ptr_q;
    lane_buf_d = lane_buf_q;
    psum_i     = '0;
    wr_idx     = '0;

    if (consume) begin
      if (beat_last) begin
        state_d = IDLE;
      end else begin
        ptr_d = ptr_q + PTR_W'(OUT_LANES);
      end
    end

    if (accept) begin
      state_d = DRAIN;
      ptr_d   = '0;
      total_d = PTR_W'(bus.in_psum[(N-1)*PSUM_W +: PSUM_W]);
      for (int j = 0; j < N; j++) begin
        lane_buf_d[j] = '0;
      end
      for (int i = 0; i < N; i++) begin
        psum_i = bus.in_psum[i*PSUM_W +: PSUM_W];
        // Out-of-range prefix sums are dropped rather than aliased into the buffer.
        if (bus.in_mask[i] && (psum_i != '0) && (psum_i <= PSUM_W'(N))) begin
          wr_idx             = IDX_W'(psum_i - PSUM_W'(1));
          lane_buf_d[wr_idx] = bus.in_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin : state_regs
    if (reset) begin
      state_q <= IDLE;
      total_q <= '0;
      ptr_q   <= '0;
      for (int j = 0; j < N; j++) begin
        lane_buf_q[j] <= '0;
      end
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      ptr_q   <= ptr_d;
      for (int j = 0; j < N; j++) begin
        lane_buf_q[j] <= lane_buf_d[j];
      end
    end
  end
endmodule

// File: tb/tb_mask_compact_packer.sv
// Randomized and directed bench for mask_compact_packer against a frame-to-beat queue model.
module tb_mask_compact_packer;
  localparam int N         = 128;
  localparam int DATA_W    = 8;
  localparam int PSUM_W    = 8;
  localparam int OUT_LANES = 16;
  localparam int CNT_W     = $clog2(OUT_LANES) + 1;
  localparam int BW        = OUT_LANES * DATA_W;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mask_compact_packer_if #(.N(N), .DATA_W(DATA_W), .PSUM_W(PSUM_W), .OUT_LANES(OUT_LANES)) bus ();

  mask_compact_packer #(.N(N), .DATA_W(DATA_W), .PSUM_W(PSUM_W), .OUT_LANES(OUT_LANES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [N-1:0]        mask;
    logic [N*DATA_W-1:0] data;
  } frame_t;

  typedef struct packed {
    logic [BW-1:0]    data;
    logic [CNT_W-1:0] cnt;
    logic             last;
  } beat_t;

  frame_t pend[$];
  beat_t  exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     ready_mode = 0;
  int     stall_lo = 0;
  int     stall_hi = 0;

  task automatic check_val(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: kept lanes in index order, chopped into OUT_LANES chunks, at least one beat.
  task automatic push_beats(input frame_t f);
    logic [DATA_W-1:0] kept[$];
    beat_t b;
    int nb, k;
    for (int i = 0; i < N; i++)
      if (f.mask[i]) kept.push_back(f.data[i*DATA_W +: DATA_W]);
    nb = (kept.size() + OUT_LANES - 1) / OUT_LANES;
    if (nb == 0) nb = 1;
    for (int bi = 0; bi < nb; bi++) begin
      b = '0;
      for (int l = 0; l < OUT_LANES; l++) begin
        k = bi * OUT_LANES + l;
        if (k < kept.size()) begin
          b.data[l*DATA_W +: DATA_W] = kept[k];
          b.cnt = b.cnt + 1'b1;
        end
      end
      b.last = (bi == nb - 1);
      exp_q.push_back(b);
    end
  endtask

  function automatic logic [N*DATA_W-1:0] ramp_data(input logic [DATA_W-1:0] base);
    logic [N*DATA_W-1:0] d;
    for (int i = 0; i < N; i++) d[i*DATA_W +: DATA_W] = base + DATA_W'(i);
    return d;
  endfunction

  function automatic frame_t rand_frame(input int dens);
    frame_t f;
    for (int i = 0; i < N; i++) begin
      f.mask[i] = ($urandom_range(0, 99) < dens);
      f.data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    end
    return f;
  endfunction

  task automatic drive_inputs();
    int c;
    logic [N*PSUM_W-1:0] ps;
    if (pend.size() > 0) begin
      c = 0;
      for (int i = 0; i < N; i++) begin
        c += int'(pend[0].mask[i]);
        ps[i*PSUM_W +: PSUM_W] = PSUM_W'(c);
      end
      bus.in_valid = 1'b1;
      bus.in_mask  = pend[0].mask;
      bus.in_data  = pend[0].data;
      bus.in_psum  = ps;
    end else begin
      bus.in_valid = 1'b0;
      bus.in_mask  = N'($urandom);
    end
    case (ready_mode)
      1:       bus.out_ready = ($urandom_range(0, 3) != 0);
      2:       bus.out_ready = !(cyc >= stall_lo && cyc < stall_hi);
      default: bus.out_ready = 1'b1;
    endcase
  endtask

  // One clock: drive at the falling edge, check just after, advance the model for the rising edge.
  task automatic step();
    logic exp_valid, exp_rdy, consume, accept;
    drive_inputs();
    #1;
    exp_valid = (exp_q.size() > 0);
    exp_rdy   = (exp_q.size() == 0) || (exp_q.size() == 1 && bus.out_ready);
    check_val("out_valid", BW'(bus.out_valid), BW'(exp_valid));
    check_val("in_ready", BW'(bus.in_ready), BW'(exp_rdy));
    if (exp_valid) begin
      check_val("out_data", bus.out_data, exp_q[0].data);
      check_val("out_count", BW'(bus.out_count), BW'(exp_q[0].cnt));
      check_val("out_last", BW'(bus.out_last), BW'(exp_q[0].last));
    end
    consume = exp_valid && bus.out_ready;
    accept  = bus.in_valid && exp_rdy;
    if (consume) void'(exp_q.pop_front());
    if (accept) begin
      push_beats(pend[0]);
      void'(pend.pop_front());
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((pend.size() > 0 || exp_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    check_val("drain_done", BW'(pend.size() == 0 && exp_q.size() == 0), BW'(1));
    step();
  endtask

  frame_t f, f1, f3;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_mask   = '0;
    bus.in_data   = '0;
    bus.in_psum   = '0;
    bus.out_ready = 1'b0;

    #1 reset = 1'b1;
    #1;
    check_val("rst_out_valid", BW'(bus.out_valid), BW'(0));
    check_val("rst_out_data", bus.out_data, BW'(0));
    check_val("rst_out_count", BW'(bus.out_count), BW'(0));
    check_val("rst_out_last", BW'(bus.out_last), BW'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    f1.mask = '0;
    f1.mask[0] = 1'b1; f1.mask[1] = 1'b1; f1.mask[4] = 1'b1;
    f1.data = ramp_data(8'hA0);
    pend.push_back(f1);
    drain(50);

    f.mask = '1;
    f.data = ramp_data(8'h00);
    pend.push_back(f);
    drain(50);

    f3.mask = {4{32'b00001000000010000010000000010011}};
    f3.data = ramp_data(8'h40);
    pend.push_back(f3);
    drain(50);

    f.mask = '0;
    f.data = ramp_data(8'h55);
    pend.push_back(f);
    drain(50);

    ready_mode = 2;
    stall_lo = cyc + 4;
    stall_hi = cyc + 7;
    f.mask = '1;
    f.data = ramp_data(8'h00);
    pend.push_back(f);
    drain(60);
    ready_mode = 0;

    pend.push_back(f);
    repeat (4) step();
    reset = 1'b1;
    #1;
    check_val("midrst_out_valid", BW'(bus.out_valid), BW'(0));
    check_val("midrst_out_data", bus.out_data, BW'(0));
    check_val("midrst_out_count", BW'(bus.out_count), BW'(0));
    check_val("midrst_out_last", BW'(bus.out_last), BW'(0));
    pend.delete();
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    f.data = ramp_data(8'h80);
    pend.push_back(f);
    drain(50);

    pend.push_back(f3);
    pend.push_back(f1);
    drain(50);

    ready_mode = 1;
    for (int r = 0; r < 30; r++) begin
      case ($urandom_range(0, 4))
        0:       pend.push_back(rand_frame(0));
        1:       pend.push_back(rand_frame(5));
        2:       pend.push_back(rand_frame(30));
        3:       pend.push_back(rand_frame(75));
        default: pend.push_back(rand_frame(100));
      endcase
    end
    drain(3000);

    ready_mode = 0;
    for (int r = 0; r < 10; r++) pend.push_back(rand_frame($urandom_range(0, 100)));
    drain(1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
